// File: rtl/nios_mtl_sysid_checker.sv
// Reads the system-ID slave (ID word, then build timestamp) and compares both words against
// the expected build values, reporting pass/fail for boot release.
module nios_mtl_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h56FB_8DEB,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] TmoLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] RetryMax = CntW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle, StReqId, StWaitId, StReqTs, StWaitTs, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic [CntW-1:0] retry_q, retry_d;
  logic            kick_q, kick_d;
  logic            id_got_q, id_got_d;
  logic            id_mis_q, id_mis_d;
  logic            ts_mis_q, ts_mis_d;
  logic            tmo_err_q, tmo_err_d;
  logic [31:0]     cap_id_q, cap_id_d;
  logic [31:0]     cap_ts_q, cap_ts_d;

  logic in_req, in_wait, is_ts, accept, got;

  assign in_req  = (state_q == StReqId) || (state_q == StReqTs);
  assign in_wait = (state_q == StWaitId) || (state_q == StWaitTs);
  assign is_ts   = (state_q == StReqTs) || (state_q == StWaitTs);
  assign accept  = in_req && !avm_waitrequest;
  // Zero-latency responses are only trusted in the acceptance cycle itself.
  assign got     = (accept || in_wait) && avm_readdatavalid;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    kick_d    = kick_q;
    id_got_d  = id_got_q;
    id_mis_d  = id_mis_q;
    ts_mis_d  = ts_mis_q;
    tmo_err_d = tmo_err_q;
    cap_id_d  = cap_id_q;
    cap_ts_d  = cap_ts_q;

    unique case (state_q)
      StIdle: begin
        if (kick_q || start) begin
          state_d   = StReqId;
          kick_d    = 1'b0;
          tmo_d     = '0;
          retry_d   = '0;
          id_got_d  = 1'b0;
          id_mis_d  = 1'b0;
          ts_mis_d  = 1'b0;
          tmo_err_d = 1'b0;
        end
      end
      StReqId, StWaitId, StReqTs, StWaitTs: begin
        if (got) begin
          tmo_d   = '0;
          retry_d = '0;
          if (!is_ts) begin
            cap_id_d = avm_readdata;
            id_got_d = 1'b1;
            state_d  = StReqTs;
          end else begin
            cap_ts_d = avm_readdata;
            id_mis_d = (cap_id_q != EXPECTED_ID);
            ts_mis_d = (avm_readdata != EXPECTED_TS);
            state_d  = StDone;
          end
        end else if (tmo_q == TmoLast) begin
          tmo_d = '0;
          if (retry_q < RetryMax) begin
            retry_d = retry_q + CntW'(1);
            state_d = is_ts ? StReqTs : StReqId;
          end else begin
            // The unread word keeps its flag clear; only a captured ID is judged.
            tmo_err_d = 1'b1;
            id_mis_d  = id_got_q && (cap_id_q != EXPECTED_ID);
            ts_mis_d  = 1'b0;
            state_d   = StDone;
          end
        end else begin
          tmo_d = tmo_q + CntW'(1);
          if (accept) state_d = is_ts ? StWaitTs : StWaitId;
        end
      end
      StDone: begin
        if (start) begin
          state_d   = StIdle;
          kick_d    = 1'b1;
          id_mis_d  = 1'b0;
          ts_mis_d  = 1'b0;
          tmo_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      retry_q   <= '0;
      kick_q    <= 1'b1;
      id_got_q  <= 1'b0;
      id_mis_q  <= 1'b0;
      ts_mis_q  <= 1'b0;
      tmo_err_q <= 1'b0;
      cap_id_q  <= '0;
      cap_ts_q  <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      kick_q    <= kick_d;
      id_got_q  <= id_got_d;
      id_mis_q  <= id_mis_d;
      ts_mis_q  <= ts_mis_d;
      tmo_err_q <= tmo_err_d;
      cap_id_q  <= cap_id_d;
      cap_ts_q  <= cap_ts_d;
    end
  end

  assign avm_read    = in_req;
  assign avm_address = is_ts;
  assign busy        = in_req || in_wait;
  assign done        = (state_q == StDone);
  assign id_mismatch = id_mis_q;
  assign ts_mismatch = ts_mis_q;
  assign timeout_err = tmo_err_q;
  assign pass        = done && !id_mis_q && !ts_mis_q && !tmo_err_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;

endmodule
